// File: rtl/ps2_pkg.sv
// PS/2 receiver shared definitions.
//   state_t            receive FSM states
//   DATA_BITS          payload bits per frame
//   FILTER_LEN_DEFAULT default deglitch length for the PS/2 clock filter
package ps2_pkg;

    localparam int unsigned DATA_BITS          = 8;
    localparam int unsigned FILTER_LEN_DEFAULT = 8;

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StParity,
        StStop
    } state_t;

endpackage

// File: rtl/ps2_sync_filter.sv
// PS/2 line conditioning: 2-flop synchronizers on clock and data, a deglitch
// filter on the clock, and a one-cycle strobe on each filtered falling edge.
//   clk       system clock
//   reset     synchronous active-high reset (lines assumed idle-high)
//   ps2_clk   raw PS/2 clock line
//   ps2_dat   raw PS/2 data line
//   clk_fall  one-cycle strobe on a filtered 1->0 clock transition
//   dat_sync  synchronized data line; the sampled bit when clk_fall is high
module ps2_sync_filter #(
    parameter int unsigned FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2_clk,
    input  logic ps2_dat,
    output logic clk_fall,
    output logic dat_sync
);

    localparam int unsigned CW = $clog2(FILTER_LEN + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

    logic          clk_meta;
    logic          clk_sync;
    logic          dat_meta;
    logic          clk_filt;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            // Everything idles high so releasing reset never fakes an edge.
            clk_meta <= 1'b1;
            clk_sync <= 1'b1;
            dat_meta <= 1'b1;
            dat_sync <= 1'b1;
            clk_filt <= 1'b1;
            cnt      <= '0;
            clk_fall <= 1'b0;
        end else begin
            clk_meta <= ps2_clk;
            clk_sync <= clk_meta;
            dat_meta <= ps2_dat;
            dat_sync <= dat_meta;
            clk_fall <= 1'b0;
            // cnt tracks consecutive samples that disagree with the filtered level;
            // the FILTER_LEN-th such sample flips the level.
            if (clk_sync == clk_filt) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                clk_filt <= clk_sync;
                cnt      <= '0;
                clk_fall <= ~clk_sync;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver.
//   CLOCK_50  system clock
//   reset     synchronous active-high reset
//   PS2_CLK   PS/2 clock line (input only)
//   PS2_DAT   PS/2 data line (input only)
//   rx_data   last good byte, held until the next good frame
//   rx_valid  one-cycle pulse when rx_data is updated
//   rx_err    one-cycle pulse when a frame is dropped (parity, stop, timeout)
//   rx_busy   high while a frame is in progress
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 100000,
    parameter int unsigned FILTER_LEN     = FILTER_LEN_DEFAULT
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err,
    output logic       rx_busy
);

    localparam int unsigned TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam int unsigned BC_W = $clog2(DATA_BITS);
    localparam logic [BC_W-1:0] BIT_LAST = BC_W'(DATA_BITS - 1);

    logic                 clk_fall;
    logic                 dat_bit;
    state_t               state;
    logic [BC_W-1:0]      bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par;
    logic [TO_W-1:0]      to_cnt;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filter (
        .clk      (CLOCK_50),
        .reset    (reset),
        .ps2_clk  (PS2_CLK),
        .ps2_dat  (PS2_DAT),
        .clk_fall (clk_fall),
        .dat_sync (dat_bit)
    );

    assign rx_busy = (state != StIdle);

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state    <= StIdle;
            bit_cnt  <= '0;
            shift    <= '0;
            par      <= 1'b0;
            to_cnt   <= '0;
            rx_data  <= 8'h00;
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_err   <= 1'b0;
            if (state == StIdle) begin
                to_cnt <= '0;
                if (clk_fall && !dat_bit) begin
                    state   <= StData;
                    bit_cnt <= '0;
                end
            end else if (clk_fall) begin
                // An edge always beats the timeout, even on the terminal cycle.
                to_cnt <= '0;
                unique case (state)
                    StData: begin
                        shift[bit_cnt] <= dat_bit;
                        if (bit_cnt == BIT_LAST) begin
                            state <= StParity;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                    StParity: begin
                        par   <= dat_bit;
                        state <= StStop;
                    end
                    StStop: begin
                        state <= StIdle;
                        if (dat_bit && ((^shift) ^ par)) begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                    end
                    default: state <= StIdle;
                endcase
            end else if (to_cnt == TO_LAST) begin
                // TIMEOUT_CYCLES edge-free cycles: drop the frame. The counter
                // never passes this value, so it cannot wrap.
                rx_err <= 1'b1;
                state  <= StIdle;
                shift  <= '0;
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 1'b1;
            end
        end
    end

endmodule

// File: doc/ps2_rx.md
PS2_RX -- requirements
Module: ps2_rx

Interface
REQ-001 TIMEOUT_CYCLES, 100000, max CLOCK_50 cycles between accepted PS/2 clock edges inside a frame (2 ms at 50 MHz).
REQ-002 FILTER_LEN, 8, consecutive equal synchronized samples needed to change filtered PS/2 clock level.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 PS2_CLK  input  1  PS/2 clock line, sampled only; the block never drives it.
REQ-006 PS2_DAT  input  1  PS/2 data line, sampled only.
REQ-007 rx_data  output  8  last correctly received byte; holds until the next good frame.
REQ-008 rx_valid  output  1  one-cycle pulse: rx_data newly updated.
REQ-009 rx_err  output  1  one-cycle pulse: frame dropped (parity, stop, or timeout).
REQ-010 rx_busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-011 PS2_CLK and PS2_DAT SHALL each pass through a 2-flop synchronizer before any use.
REQ-012 Filtered clock SHALL go 0 only after FILTER_LEN consecutive synchronized 0 samples, and 1 only after FILTER_LEN consecutive 1 samples; otherwise it holds.
REQ-013 Accepted edge = filtered clock 1->0 transition, a strobe lasting exactly one cycle; on that cycle the synchronized PS2_DAT value SHALL be the sampled bit.
REQ-014 Frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-015 FSM states: IDLE, DATA, PARITY, STOP.
REQ-016 IDLE: on an edge with bit=0, go to DATA with bit counter 0; with bit=1, stay in IDLE with no error.
REQ-017 DATA: each edge shifts the bit into the shift register at bit[counter]; after the 8th bit, go to PARITY.
REQ-018 PARITY: the edge stores the parity bit, then go to STOP.
REQ-019 STOP: the edge returns to IDLE; the frame is good iff stop=1 and (XOR of data bits XOR parity)=1.
REQ-020 Good frame: the cycle after the stop edge, load rx_data and pulse rx_valid for 1 cycle.
REQ-021 Bad frame: the cycle after the stop edge, pulse rx_err for 1 cycle; rx_data is unchanged.
REQ-022 Timeout: in any non-IDLE state, a counter is cleared on every edge and increments otherwise; reaching TIMEOUT_CYCLES pulses rx_err the next cycle and returns to IDLE, discarding partial data.
REQ-023 If an edge and the timeout terminal count occur in the same cycle, the edge wins: the counter clears and no error is raised.
REQ-024 rx_valid and rx_err SHALL never be high in the same cycle; at most one pulse per frame.
REQ-025 The counter SHALL saturate and never wrap; in IDLE it is held at 0.

Reset
REQ-026 While reset=1: FSM=IDLE; counters=0; shift register=0; rx_data=0x00; rx_valid=0; rx_err=0; rx_busy=0.
REQ-027 On reset, synchronizer flops and the filtered clock SHALL take value 1 (bus idle), so no spurious edge follows reset release.
REQ-028 Reset mid-frame SHALL discard the partial frame without raising rx_err.

Structure
REQ-029 Package ps2_pkg SHALL hold the state enum, DATA_BITS=8, and the FILTER_LEN default.
REQ-030 Sub-module ps2_sync_filter SHALL contain the synchronizers, deglitch filter, and edge strobe; the FSM lives in ps2_rx.

Verification
REQ-031 Bench PS/2 clock half-period is 2000 cycles; frame 0x1C with parity 0 and stop 1 -> rx_data=0x1C, exactly one rx_valid, no rx_err.
REQ-032 Frame 0x1C with parity 1 -> one rx_err, no rx_valid, rx_data keeps its prior value.
REQ-033 Frame 0x5A with stop 0 -> one rx_err; a following good frame 0xF0 (parity 1) -> rx_data=0xF0.
REQ-034 Start bit plus 3 data bits, then clock held high -> rx_err exactly TIMEOUT_CYCLES+1 cycles after the last edge, rx_busy drops; a subsequent 0xF0 frame is received correctly.
REQ-035 In IDLE with PS2_DAT=0, a 3-cycle low glitch on PS2_CLK -> no edge strobe, rx_busy stays 0.
REQ-036 reset pulse after 5 data bits -> all outputs at reset values, no rx_err; the next frame 0x5A (parity 1) -> rx_data=0x5A with one rx_valid.
